// File: rtl/sha_pkg.sv
`default_nettype none
// ============================================================================
// sha_pkg : shared state encoding, key codes and helpers for the alarm block
// Rev 1.0
// ============================================================================
package sha_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_DISARMED  = 3'd0,
    ST_EXIT_DLY  = 3'd1,
    ST_ARMED     = 3'd2,
    ST_ENTRY_DLY = 3'd3,
    ST_ALARM     = 3'd4
  } state_t;

  localparam logic [3:0] KEY_CLEAR     = 4'hA;
  localparam logic [3:0] KEY_MAX_DIGIT = 4'h9;

  function automatic logic is_digit(input logic [3:0] key);
    return key <= KEY_MAX_DIGIT;
  endfunction

  function automatic logic is_armed_state(input state_t s);
    return (s == ST_ARMED) || (s == ST_ENTRY_DLY) || (s == ST_ALARM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sensor_sync_bank.sv
`default_nettype none
// ============================================================================
// sensor_sync_bank : per-bit two-flop synchroniser for asynchronous sensor inputs
// Rev 1.0
// ============================================================================
module sensor_sync_bank #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/multi_zone_alarm_ctrl.sv
`default_nettype none
// ============================================================================
// multi_zone_alarm_ctrl : keypad-armed multi-zone intrusion alarm controller
// Optional: SHA_FIRE_ZONE_EN makes zone 0 a 24-hour fire zone.    Rev 1.0
// ============================================================================
module multi_zone_alarm_ctrl
  import sha_pkg::*;
#(
  parameter int NUM_ZONES      = 8,
  parameter int PW_DIGITS      = 4,
  parameter int EXIT_CYCLES    = 1000,
  parameter int ENTRY_CYCLES   = 1000,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 5000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_ZONES-1:0]   zone_in,
  input  logic [NUM_ZONES-1:0]   zone_mask,
  input  logic                   key_valid,
  input  logic [3:0]             key_value,
  input  logic [4*PW_DIGITS-1:0] stored_password,
  output logic [STATE_W-1:0]     state,
  output logic                   armed,
  output logic [NUM_ZONES-1:0]   alarm_zones,
  output logic                   siren,
  output logic                   buzzer,
  output logic                   pw_ok,
  output logic                   locked_out
);

  localparam int c_pw_w    = 4 * PW_DIGITS;
  localparam int c_cnt_w   = $clog2(PW_DIGITS + 1);
  localparam int c_try_w   = $clog2(MAX_TRIES + 1);
  localparam int c_lck_w   = $clog2(LOCKOUT_CYCLES + 1);
  localparam int c_dly_max = (EXIT_CYCLES > ENTRY_CYCLES) ? EXIT_CYCLES : ENTRY_CYCLES;
  localparam int c_dly_w   = $clog2(c_dly_max + 1);

  localparam logic [c_dly_w-1:0] c_exit_ld  = c_dly_w'(EXIT_CYCLES - 1);
  localparam logic [c_dly_w-1:0] c_entry_ld = c_dly_w'(ENTRY_CYCLES - 1);
  localparam logic [c_lck_w-1:0] c_lock_ld  = c_lck_w'(LOCKOUT_CYCLES - 1);
  localparam logic [c_try_w-1:0] c_last_try = c_try_w'(MAX_TRIES - 1);
  localparam logic [c_cnt_w-1:0] c_last_dig = c_cnt_w'(PW_DIGITS - 1);

  logic [NUM_ZONES-1:0] w_zone_sync;
  logic [NUM_ZONES-1:0] w_active;
  logic                 w_fire;

  logic [c_pw_w-1:0]    r_buf;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_try_w-1:0]   r_fail;
  logic [c_lck_w-1:0]   r_lck_cnt;
  logic                 r_locked;
  logic                 r_pw_ok;
  logic                 r_buzzer;
  logic [c_pw_w-1:0]    w_buf_shift;

  state_t               r_state;
  state_t               w_next_state;
  logic [NUM_ZONES-1:0] r_alarm_zones;
  logic [NUM_ZONES-1:0] w_next_zones;
  logic [c_dly_w-1:0]   r_dly_cnt;
  logic                 r_armed;
  logic                 r_siren;

  sensor_sync_bank #(
    .WIDTH (NUM_ZONES)
  ) u_zone_sync (
    .clk   (clk),
    .reset (reset),
    .d     (zone_in),
    .q     (w_zone_sync)
  );

  always_comb begin
    w_active = w_zone_sync & ~zone_mask;
`ifdef SHA_FIRE_ZONE_EN
    w_active[0] = w_zone_sync[0];
    w_fire      = w_zone_sync[0];
`else
    w_fire      = 1'b0;
`endif
  end

  // First digit keyed ends up in the most-significant nibble.
  assign w_buf_shift = (r_buf << 4) | c_pw_w'(key_value);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buf     <= '0;
      r_cnt     <= '0;
      r_fail    <= '0;
      r_lck_cnt <= '0;
      r_locked  <= 1'b0;
      r_pw_ok   <= 1'b0;
      r_buzzer  <= 1'b0;
    end else begin
      r_pw_ok  <= 1'b0;
      r_buzzer <= 1'b0;
      if (r_locked) begin
        if (r_lck_cnt == '0) begin
          r_locked <= 1'b0;
          r_fail   <= '0;
        end else begin
          r_lck_cnt <= r_lck_cnt - 1'b1;
        end
      end else if (key_valid) begin
        if (is_digit(key_value)) begin
          if (r_cnt == c_last_dig) begin
            r_buf <= '0;
            r_cnt <= '0;
            if (w_buf_shift == stored_password) begin
              r_pw_ok <= 1'b1;
              r_fail  <= '0;
            end else begin
              r_buzzer <= 1'b1;
              r_fail   <= r_fail + 1'b1;
              if (r_fail == c_last_try) begin
                r_locked  <= 1'b1;
                r_lck_cnt <= c_lock_ld;
              end
            end
          end else begin
            r_buf <= w_buf_shift;
            r_cnt <= r_cnt + 1'b1;
          end
        end else if (key_value == KEY_CLEAR) begin
          r_buf <= '0;
          r_cnt <= '0;
        end
      end
    end
  end

  // A registered pw_ok outranks both zone activity and delay expiry.
  always_comb begin
    w_next_state = r_state;
    w_next_zones = r_alarm_zones;
    if (r_pw_ok) begin
      if (r_state == ST_DISARMED) begin
        w_next_state = ST_EXIT_DLY;
      end else begin
        w_next_state = ST_DISARMED;
        w_next_zones = '0;
      end
    end else if (w_fire) begin
      w_next_state = ST_ALARM;
      if (is_armed_state(r_state)) begin
        w_next_zones = r_alarm_zones | w_active;
      end else begin
        w_next_zones[0] = 1'b1;
      end
    end else begin
      unique case (r_state)
        ST_DISARMED: ;
        ST_EXIT_DLY: begin
          if (r_dly_cnt == '0) w_next_state = ST_ARMED;
        end
        ST_ARMED: begin
          if (|w_active) begin
            w_next_state = ST_ENTRY_DLY;
            w_next_zones = r_alarm_zones | w_active;
          end
        end
        ST_ENTRY_DLY: begin
          w_next_zones = r_alarm_zones | w_active;
          if (r_dly_cnt == '0) w_next_state = ST_ALARM;
        end
        ST_ALARM: begin
          w_next_zones = r_alarm_zones | w_active;
        end
        default: w_next_state = ST_DISARMED;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_DISARMED;
      r_alarm_zones <= '0;
      r_dly_cnt     <= '0;
      r_armed       <= 1'b0;
      r_siren       <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_alarm_zones <= w_next_zones;
      r_armed       <= is_armed_state(w_next_state);
      r_siren       <= (w_next_state == ST_ALARM);
      if (w_next_state != r_state) begin
        if (w_next_state == ST_EXIT_DLY)       r_dly_cnt <= c_exit_ld;
        else if (w_next_state == ST_ENTRY_DLY) r_dly_cnt <= c_entry_ld;
        else                                   r_dly_cnt <= '0;
      end else if (r_dly_cnt != '0) begin
        r_dly_cnt <= r_dly_cnt - 1'b1;
      end
    end
  end

  assign state       = r_state;
  assign armed       = r_armed;
  assign alarm_zones = r_alarm_zones;
  assign siren       = r_siren;
  assign buzzer      = r_buzzer;
  assign pw_ok       = r_pw_ok;
  assign locked_out  = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_multi_zone_alarm_ctrl.sv
`default_nettype none
// ============================================================================
// tb_multi_zone_alarm_ctrl : scoreboard bench with a deadline-based reference model
// Honours SHA_FIRE_ZONE_EN when the design is built with it.    Rev 1.0
// ============================================================================
module tb_multi_zone_alarm_ctrl;

  localparam int PW      = 4;
  localparam int EXIT_C  = 1000;
  localparam int ENTRY_C = 1000;
  localparam int TRIES   = 3;
  localparam int LOCK_C  = 5000;

  localparam int S_DIS   = 0;
  localparam int S_EXIT  = 1;
  localparam int S_ARMED = 2;
  localparam int S_ENTRY = 3;
  localparam int S_ALARM = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  zone_in = '0;
  logic [7:0]  zone_mask = '0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_value = '0;
  logic [15:0] stored_password = 16'h1234;
  logic [2:0]  state;
  logic        armed;
  logic [7:0]  alarm_zones;
  logic        siren;
  logic        buzzer;
  logic        pw_ok;
  logic        locked_out;

  multi_zone_alarm_ctrl #(
    .NUM_ZONES      (8),
    .PW_DIGITS      (PW),
    .EXIT_CYCLES    (EXIT_C),
    .ENTRY_CYCLES   (ENTRY_C),
    .MAX_TRIES      (TRIES),
    .LOCKOUT_CYCLES (LOCK_C)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .zone_in         (zone_in),
    .zone_mask       (zone_mask),
    .key_valid       (key_valid),
    .key_value       (key_value),
    .stored_password (stored_password),
    .state           (state),
    .armed           (armed),
    .alarm_zones     (alarm_zones),
    .siren           (siren),
    .buzzer          (buzzer),
    .pw_ok           (pw_ok),
    .locked_out      (locked_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [2:0] st;
    logic       armed;
    logic [7:0] zones;
    logic       siren;
    logic       bz;
    logic       ok;
    logic       lk;
  } snap_t;

  snap_t exp_q[$];
  int    checks = 0;
  int    passed = 0;

  // Reference model: expected behaviour after each rising edge.
  int         edge_n = 0;
  int         m_state = S_DIS;
  logic [7:0] m_zones = '0;
  int         m_deadline = 0;
  bit         m_ok = 0, m_bz = 0, m_locked = 0;
  int         m_lock_end = 0;
  int         m_fail = 0;
  int         digits[$];
  logic [7:0] zhist[$];

  logic        nxt_reset = 1'b1;
  logic [7:0]  nxt_zone = '0;
  logic [7:0]  nxt_mask = '0;
  logic        nxt_kv = 1'b0;
  logic [3:0]  nxt_key = '0;

  function automatic bit st_armed(int s);
    return (s == S_ARMED) || (s == S_ENTRY) || (s == S_ALARM);
  endfunction

  task automatic model_reset();
    m_state = S_DIS; m_zones = '0; m_ok = 0; m_bz = 0;
    m_locked = 0; m_fail = 0;
    digits.delete();
    zhist.delete();
  endtask

  task automatic model_edge();
    logic [7:0] sync, active;
    bit ok_prev, match;
    edge_n++;
    if (reset) begin
      model_reset();
      return;
    end
    // The FSM sees zone_in as it was sampled two edges earlier.
    sync = (zhist.size() >= 2) ? zhist[zhist.size()-2] : 8'h00;
    zhist.push_back(zone_in);
    if (zhist.size() > 2) void'(zhist.pop_front());
    active = sync & ~zone_mask;
`ifdef SHA_FIRE_ZONE_EN
    active[0] = sync[0];
`endif
    ok_prev = m_ok;
    if (ok_prev) begin
      if (m_state == S_DIS) begin
        m_state = S_EXIT; m_deadline = edge_n + EXIT_C;
      end else begin
        m_state = S_DIS; m_zones = '0;
      end
    end
`ifdef SHA_FIRE_ZONE_EN
    else if (sync[0]) begin
      if (st_armed(m_state)) m_zones = m_zones | active;
      else m_zones[0] = 1'b1;
      m_state = S_ALARM;
    end
`endif
    else begin
      case (m_state)
        S_EXIT:  if (edge_n == m_deadline) m_state = S_ARMED;
        S_ARMED: if (active != 0) begin
          m_state = S_ENTRY; m_deadline = edge_n + ENTRY_C; m_zones = m_zones | active;
        end
        S_ENTRY: begin
          m_zones = m_zones | active;
          if (edge_n == m_deadline) m_state = S_ALARM;
        end
        S_ALARM: m_zones = m_zones | active;
        default: ;
      endcase
    end

    m_ok = 0; m_bz = 0;
    if (m_locked) begin
      if (edge_n == m_lock_end) begin m_locked = 0; m_fail = 0; end
    end else if (key_valid) begin
      if (key_value <= 4'd9) begin
        digits.push_back(int'(key_value));
        if (digits.size() == PW) begin
          match = 1;
          for (int i = 0; i < PW; i++)
            if (digits[i] != int'((stored_password >> (4*(PW-1-i))) & 16'hF)) match = 0;
          digits.delete();
          if (match) begin
            m_ok = 1; m_fail = 0;
          end else begin
            m_bz = 1; m_fail++;
            if (m_fail == TRIES) begin m_locked = 1; m_lock_end = edge_n + LOCK_C; end
          end
        end
      end else if (key_value == 4'hA) begin
        digits.delete();
      end
    end
  endtask

  task automatic push_snapshot();
    snap_t s;
    s.cyc = edge_n; s.st = 3'(m_state); s.armed = st_armed(m_state);
    s.zones = m_zones; s.siren = (m_state == S_ALARM);
    s.bz = m_bz; s.ok = m_ok; s.lk = m_locked;
    exp_q.push_back(s);
  endtask

  // One clock: model the edge, then drive the next inputs (and any async reset).
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    reset = nxt_reset; zone_in = nxt_zone; zone_mask = nxt_mask;
    key_valid = nxt_kv; key_value = nxt_key;
    if (reset) model_reset();
    push_snapshot();
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input logic [3:0] k);
    nxt_kv = 1'b1; nxt_key = k; tick();
    nxt_kv = 1'b0; tick();
  endtask

  task automatic enter_code(input logic [15:0] code);
    for (int i = 0; i < PW; i++) press(code[15-4*i -: 4]);
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] c = '0;
    for (int i = 0; i < PW; i++) c = (c << 4) | 16'($urandom_range(0, 9));
    return c;
  endfunction

  snap_t mon_e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if ({state, armed, alarm_zones, siren, buzzer, pw_ok, locked_out} ===
          {mon_e.st, mon_e.armed, mon_e.zones, mon_e.siren, mon_e.bz, mon_e.ok, mon_e.lk})
        passed++;
      else
        $display("FAIL cycle %0d: got st=%0d armed=%0b zones=%02h siren=%0b buz=%0b ok=%0b lock=%0b; expected st=%0d armed=%0b zones=%02h siren=%0b buz=%0b ok=%0b lock=%0b",
                 mon_e.cyc, state, armed, alarm_zones, siren, buzzer, pw_ok, locked_out,
                 mon_e.st, mon_e.armed, mon_e.zones, mon_e.siren, mon_e.bz, mon_e.ok, mon_e.lk);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d passed=%0d", checks, passed);
    $fatal(1);
  end

  initial begin
    logic [15:0] wrong;
    int r;

    wait_cycles(3);
    nxt_reset = 1'b0;
    tick();

    // Correct code arms; exit delay expires into ARMED.
    enter_code(16'h1234);
    wait_cycles(EXIT_C + 10);

    // Intrusion on zone 2 -> entry delay -> alarm -> disarm.
    nxt_zone = 8'h04; wait_cycles(5);
    nxt_zone = 8'h00; wait_cycles(ENTRY_C + 5);
    enter_code(16'h1234);
    wait_cycles(3);

    // Three wrong codes lock the keypad; a correct code inside the lockout is dropped.
    for (int i = 0; i < TRIES; i++) begin
      do wrong = rand_bcd(); while (wrong == stored_password);
      enter_code(wrong);
    end
    enter_code(16'h1234);
    wait_cycles(LOCK_C);
    enter_code(16'h1234);
    wait_cycles(EXIT_C + 10);

    // Masked zone keeps ARMED; trips during the exit delay are ignored.
    nxt_mask = 8'h04; nxt_zone = 8'h04; wait_cycles(10);
    nxt_zone = 8'h00;
    enter_code(16'h1234);
    wait_cycles(3);
    enter_code(16'h1234);
    nxt_zone = 8'hFA; wait_cycles(500);
    nxt_zone = 8'h00; wait_cycles(EXIT_C);

    // Reset asserted part way through an entry delay.
    nxt_zone = 8'h10; wait_cycles(20);
    nxt_zone = 8'h00; nxt_reset = 1'b1; wait_cycles(2);
    nxt_reset = 1'b0; wait_cycles(3);

`ifdef SHA_FIRE_ZONE_EN
    // Fire zone: alarm from DISARMED, re-alarm after disarm while still held.
    nxt_mask = 8'h01; nxt_zone = 8'h01; wait_cycles(6);
    enter_code(16'h1234);
    wait_cycles(4);
    nxt_zone = 8'h00; wait_cycles(4);
    enter_code(16'h1234);
    wait_cycles(4);
    nxt_mask = 8'h00;
`endif

    // Randomised traffic with a fresh password.
    stored_password = rand_bcd();
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: enter_code(stored_password);
        3: press(4'($urandom_range(0, 9)));
        4: press(4'hA);
        5: press(4'($urandom_range(11, 15)));
        6: begin nxt_zone = 8'($urandom); tick(); end
        7: begin nxt_mask = 8'($urandom); tick(); end
        8: wait_cycles($urandom_range(1, 30));
        default: begin nxt_zone = '0; wait_cycles($urandom_range(200, 1100)); end
      endcase
    end
    nxt_zone = '0;
    wait_cycles(2);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
